el2_exu_crc_ctl: RTL and testbench
==================================

Name: el2_exu_crc_ctl

Overview:
- Iterative sequencer for the Zbr CRC instructions: crc32.b/h/w and crc32c.b/h/w (the crc32_* / crc32c_* fields of the mul packet).
- Sits in EXU beside the multiplier.
- Accepts one request at a time, steps a shared reflected-CRC datapath BITS_PER_CYCLE bits per clock, and returns a one-cycle finish pulse with the 32-bit result.
- Decode stalls on crc_busy; writeback is a pipe flush.

Parameters:
- BITS_PER_CYCLE, 4, bits reduced per step; legal values 1, 2, 4, 8.
- CNT_W, 6, width of the internal step counter; must hold 32/BITS_PER_CYCLE.

Ports:
- clk  in  1  core clock
- rst_l  in  1  asynchronous active-low reset
- crc_valid  in  1  request qualifier
- crc_type  in  6  one-hot {crc32c_w, crc32c_h, crc32c_b, crc32_w, crc32_h, crc32_b}
- crc_rs1  in  32  source operand
- crc_flush  in  1  kill in-flight op (dec_tlu_flush_lower_r)
- crc_busy  out  1  unit occupied; new requests not accepted
- crc_finish  out  1  one-cycle result-valid pulse
- crc_result  out  32  result register

Behaviour:
- Reset: asynchronous on rst_l low; state=IDLE, crc_busy=0, crc_finish=0, crc_result=0, counter=0. A reset mid-operation abandons the op with no finish.
- States:
  - IDLE: crc_busy=0.
  - RUN: crc_busy=1.
  - DONE: crc_busy=1.
- Accept:
  - A request is accepted when crc_valid & state==IDLE & ~crc_flush & |crc_type.
  - crc_valid while busy is ignored; no queuing.
  - crc_type==0 is ignored.
  - If more than one bit is set, the lowest bit wins (priority b, h, w, then c-b, c-h, c-w).
- On accept edge:
  - data_reg <= crc_rs1.
  - nbits = 8/16/32 for b/h/w.
  - poly = 0xEDB88320 for crc32, 0x82F63B78 for crc32c.
  - counter <= nbits/BITS_PER_CYCLE.
  - state <= RUN.
- RUN, each cycle, for BITS_PER_CYCLE bits: x = (x >> 1) ^ (poly & {32{x[0]}}), using a 32-bit logical right shift.
  - counter decrements by 1 each cycle.
  - When counter reaches 0, crc_result <= x and state <= DONE.
- DONE: crc_finish = (state==DONE) & ~crc_flush; next state is IDLE.
- Latency: with the accept cycle as T, crc_finish is high in cycle T + nbits/BITS_PER_CYCLE + 1.
  - BITS_PER_CYCLE=4: b=T+3, h=T+5, w=T+9.
- Next request: earliest accept is the cycle after DONE, so the back-to-back issue interval is latency+1.
- crc_result holds its value until the next completion. It is not cleared by flush or by a new accept.
- crc_flush:
  - In RUN or DONE: state <= IDLE next edge, crc_finish suppressed in that cycle, crc_result unchanged.
  - In IDLE: a concurrent crc_valid is dropped.
- crc_busy is combinational from state only, with no dependence on crc_valid.

Optional Feature:
- Macro: EL2_CRC_PERF_CNT_EN.
- When defined, adds output crc_perf_cnt (out, 16 bits) with these rules:
  - Reset value is 0.
  - Increments by 1 on each cycle crc_finish=1.
  - Saturates at 0xFFFF.
  - Flushed ops are not counted.
- When undefined, the port and counter are absent and behaviour is otherwise identical.

Test Plan:
- crc32.b, rs1=0x00000001, accept at T -> crc_finish only in T+3, crc_result=0x77073096, crc_busy high T+1..T+3.
- crc32c.b, rs1=0x00000001 -> crc_result=0xF26B8303, one finish pulse.
- crc32.h, rs1=0x00000080 -> finish at T+5, crc_result=0x3B83984B; crc32.w, rs1=0 -> finish at T+9, result 0x00000000.
- Busy/collision:
  - Hold crc_valid high with a new type while RUN -> second request not taken, exactly one finish.
  - Second request accepted on the first cycle after DONE.
  - crc_type=0 with crc_valid -> no busy, no finish.
- Flush and reset:
  - crc_flush in RUN cycle T+2 of a crc32.w -> IDLE at T+3, no finish, crc_result keeps prior value.
  - crc_flush in DONE -> no pulse.
  - rst_l low mid-RUN -> all outputs 0 immediately.
- Perf counter (EL2_CRC_PERF_CNT_EN): 3 completions plus 1 flushed op -> crc_perf_cnt=3.
  - Preload near saturation by forcing 0xFFFE, then 3 completions -> 0xFFFF held.

Source files
------------

// File: rtl/el2_exu_crc_ctl_if.sv
// Request/response bundle between EXU issue logic and the CRC sequencer.
// EL2_CRC_PERF_CNT_EN adds the completion counter output.
interface el2_exu_crc_ctl_if;
   logic        crc_valid;
   logic [5:0]  crc_type;
   logic [31:0] crc_rs1;
   logic        crc_flush;
   logic        crc_busy;
   logic        crc_finish;
   logic [31:0] crc_result;
`ifdef EL2_CRC_PERF_CNT_EN
   logic [15:0] crc_perf_cnt;

   modport master (
      output crc_valid, crc_type, crc_rs1, crc_flush,
      input  crc_busy, crc_finish, crc_result, crc_perf_cnt
   );
   modport slave (
      input  crc_valid, crc_type, crc_rs1, crc_flush,
      output crc_busy, crc_finish, crc_result, crc_perf_cnt
   );
`else
   modport master (
      output crc_valid, crc_type, crc_rs1, crc_flush,
      input  crc_busy, crc_finish, crc_result
   );
   modport slave (
      input  crc_valid, crc_type, crc_rs1, crc_flush,
      output crc_busy, crc_finish, crc_result
   );
`endif
endinterface

// File: rtl/el2_exu_crc_ctl.sv
// Iterative reflected CRC32 / CRC32C sequencer for the Zbr crc32[c].b/h/w ops.
// Define EL2_CRC_PERF_CNT_EN to add a saturating completed-op counter.
module el2_exu_crc_ctl #(
   parameter int BITS_PER_CYCLE = 4,
   parameter int CNT_W          = 6
) (
   input  logic             clk,
   input  logic             rst_l,
   el2_exu_crc_ctl_if.slave crc_if
);

   localparam logic [31:0]      POLY_CRC32  = 32'hEDB88320;
   localparam logic [31:0]      POLY_CRC32C = 32'h82F63B78;
   localparam logic [CNT_W-1:0] STEPS_B     = CNT_W'(8  / BITS_PER_CYCLE);
   localparam logic [CNT_W-1:0] STEPS_H     = CNT_W'(16 / BITS_PER_CYCLE);
   localparam logic [CNT_W-1:0] STEPS_W     = CNT_W'(32 / BITS_PER_CYCLE);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t           r_state;
   state_t           w_state_nxt;
   logic [CNT_W-1:0] r_cnt;
   logic [31:0]      r_data;
   logic [31:0]      r_poly;
   logic [31:0]      r_result;
   logic [CNT_W-1:0] w_cnt_init;
   logic [31:0]      w_poly_sel;
   logic [31:0]      w_step;
   logic             w_accept;
   logic             w_last_step;
   logic             w_finish;

   function automatic logic [31:0] f_crc_step(input logic [31:0] x_in,
                                              input logic [31:0] poly);
      logic [31:0] x;
      x = x_in;
      for (int i = 0; i < BITS_PER_CYCLE; i++) begin
         x = (x >> 1) ^ (poly & {32{x[0]}});
      end
      return x;
   endfunction

   // Lowest set type bit wins when several are asserted.
   always_comb begin
      w_cnt_init = STEPS_B;
      w_poly_sel = POLY_CRC32;
      if (crc_if.crc_type[0]) begin
         w_cnt_init = STEPS_B;
         w_poly_sel = POLY_CRC32;
      end else if (crc_if.crc_type[1]) begin
         w_cnt_init = STEPS_H;
         w_poly_sel = POLY_CRC32;
      end else if (crc_if.crc_type[2]) begin
         w_cnt_init = STEPS_W;
         w_poly_sel = POLY_CRC32;
      end else if (crc_if.crc_type[3]) begin
         w_cnt_init = STEPS_B;
         w_poly_sel = POLY_CRC32C;
      end else if (crc_if.crc_type[4]) begin
         w_cnt_init = STEPS_H;
         w_poly_sel = POLY_CRC32C;
      end else if (crc_if.crc_type[5]) begin
         w_cnt_init = STEPS_W;
         w_poly_sel = POLY_CRC32C;
      end
   end

   assign w_accept    = crc_if.crc_valid & (r_state == IDLE) & ~crc_if.crc_flush
                      & (|crc_if.crc_type);
   assign w_step      = f_crc_step(r_data, r_poly);
   assign w_last_step = (r_state == RUN) & ~crc_if.crc_flush & (r_cnt == CNT_W'(1));

   always_comb begin
      w_state_nxt = r_state;
      w_finish    = 1'b0;
      case (r_state)
         IDLE: if (w_accept) w_state_nxt = RUN;
         RUN: begin
            if (crc_if.crc_flush)  w_state_nxt = IDLE;
            else if (w_last_step)  w_state_nxt = DONE;
         end
         DONE: begin
            w_finish    = ~crc_if.crc_flush;
            w_state_nxt = IDLE;
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_l) begin
      if (!rst_l) begin
         r_state  <= IDLE;
         r_cnt    <= '0;
         r_result <= '0;
      end else begin
         r_state <= w_state_nxt;
         if (w_accept) r_cnt <= w_cnt_init;
         else if ((r_state == RUN) && !crc_if.crc_flush) r_cnt <= r_cnt - CNT_W'(1);
         if (w_last_step) r_result <= w_step;
      end
   end

   // Operand/polynomial are pure data: loaded on accept, never reset.
   always_ff @(posedge clk) begin
      if (w_accept) begin
         r_data <= crc_if.crc_rs1;
         r_poly <= w_poly_sel;
      end else if (r_state == RUN) begin
         r_data <= w_step;
      end
   end

   assign crc_if.crc_busy   = (r_state != IDLE);
   assign crc_if.crc_finish = w_finish;
   assign crc_if.crc_result = r_result;

`ifdef EL2_CRC_PERF_CNT_EN
   logic [15:0] r_perf_cnt;

   always_ff @(posedge clk or negedge rst_l) begin
      if (!rst_l) begin
         r_perf_cnt <= '0;
      end else if (w_finish && (r_perf_cnt != 16'hFFFF)) begin
         r_perf_cnt <= r_perf_cnt + 16'd1;
      end
   end

   assign crc_if.crc_perf_cnt = r_perf_cnt;
`endif

endmodule

// File: tb/tb_el2_exu_crc_ctl.sv
// Scoreboard bench for el2_exu_crc_ctl: stimulus queues expected completions,
// a negedge monitor compares finish timing, result, busy and perf counter.
module tb_el2_exu_crc_ctl;
   localparam int BPC = 4;

   logic clk;
   logic rst_l;
   int   cyc;
   int   total;
   int   bad;
   bit   mon_en;
   int   busy_lo;
   int   busy_hi;
   logic [31:0] last_res;
   logic [15:0] perf_model;

   typedef struct {
      int          cyc;
      logic [31:0] res;
      bit          fin;
   } exp_t;

   exp_t q[$];
   exp_t mon_e;
   bit   mon_fin;

   el2_exu_crc_ctl_if crc_if ();

   el2_exu_crc_ctl #(.BITS_PER_CYCLE(BPC), .CNT_W(6)) dut (
      .clk    (clk),
      .rst_l  (rst_l),
      .crc_if (crc_if)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s cyc=%0d got=%h want=%h", nm, cyc, act, exp);
      end
   endtask

   function automatic int idx_of(input logic [5:0] t);
      int idx;
      idx = 0;
      for (int i = 5; i >= 0; i--) if (t[i]) idx = i;
      return idx;
   endfunction

   function automatic int nbits_of(input logic [5:0] t);
      return 8 << (idx_of(t) % 3);
   endfunction

   // Reference CRC: whole-operand bitwise reduction, no step counter.
   function automatic logic [31:0] ref_crc(input logic [5:0] t, input logic [31:0] d);
      logic [31:0] x;
      logic [31:0] poly;
      poly = (idx_of(t) < 3) ? 32'hEDB88320 : 32'h82F63B78;
      x = d;
      for (int i = 0; i < nbits_of(t); i++) x = x[0] ? ((x >> 1) ^ poly) : (x >> 1);
      return x;
   endfunction

   always @(negedge clk) begin
      if (mon_en) begin
`ifdef EL2_CRC_PERF_CNT_EN
         chk("perf_cnt", 32'(crc_if.crc_perf_cnt), 32'(perf_model));
`endif
         chk("busy", 32'(crc_if.crc_busy), 32'((cyc >= busy_lo) && (cyc <= busy_hi)));
         while (q.size() > 0 && q[0].cyc < cyc) begin
            mon_e = q.pop_front();
            chk("missed_slot", 32'(cyc), 32'(mon_e.cyc));
         end
         mon_fin = 1'b0;
         if (q.size() > 0 && q[0].cyc == cyc) begin
            mon_e    = q.pop_front();
            mon_fin  = mon_e.fin;
            last_res = mon_e.res;
         end
         chk("finish", 32'(crc_if.crc_finish), 32'(mon_fin));
         chk("result", crc_if.crc_result, last_res);
         if (mon_fin && perf_model != 16'hFFFF) perf_model = perf_model + 16'd1;
      end
   end

   // Called at #1 after the edge that starts the accept cycle; returns with DUT idle.
   task automatic run_op(input logic [5:0] t, input logic [31:0] d, input logic [31:0] exp_res,
                         input int flush_off, input bit hold);
      int   t0;
      int   fin;
      int   c;
      exp_t e;
      t0 = cyc;
      crc_if.crc_valid = 1'b1;
      crc_if.crc_type  = t;
      crc_if.crc_rs1   = d;
      crc_if.crc_flush = 1'b0;
      if (t == 6'd0) begin
         @(posedge clk); #1;
         crc_if.crc_valid = 1'b0;
         return;
      end
      fin   = t0 + nbits_of(t) / BPC + 1;
      e.cyc = fin;
      e.res = exp_res;
      e.fin = 1'b1;
      q.push_back(e);
      busy_lo = t0 + 1;
      busy_hi = fin;
      @(posedge clk); #1;
      c = t0 + 1;
      if (!hold) crc_if.crc_valid = 1'b0;
      while (1) begin
         if (hold) begin
            crc_if.crc_type = 6'($urandom);
            crc_if.crc_rs1  = $urandom;
         end
         if (flush_off != 0 && c == t0 + flush_off) begin
            crc_if.crc_flush = 1'b1;
            e = q.pop_back();
            if (c < fin) begin
               busy_hi = c;
            end else begin
               e.fin = 1'b0;
               q.push_back(e);
            end
            @(posedge clk); #1;
            crc_if.crc_flush = 1'b0;
            crc_if.crc_valid = 1'b0;
            return;
         end
         @(posedge clk); #1;
         if (c == fin) begin
            crc_if.crc_valid = 1'b0;
            return;
         end
         c++;
      end
   endtask

   task automatic idle_cycle(input int kind);
      crc_if.crc_valid = (kind != 0);
      crc_if.crc_type  = (kind == 2) ? 6'(1 << $urandom_range(0, 5)) : 6'd0;
      crc_if.crc_rs1   = $urandom;
      crc_if.crc_flush = (kind == 2);
      @(posedge clk); #1;
      crc_if.crc_valid = 1'b0;
      crc_if.crc_flush = 1'b0;
   endtask

   initial begin
      #500000;
      $display("FAIL timeout cyc=%0d", cyc);
      $fatal(1, "timeout");
   end

   initial begin
      logic [5:0]  t;
      logic [31:0] d;
      int          fo;
      total = 0; bad = 0; cyc = 0; mon_en = 1'b0;
      busy_lo = 1; busy_hi = 0; last_res = '0; perf_model = '0;
      rst_l = 1'b0;
      crc_if.crc_valid = 1'b0; crc_if.crc_type = '0; crc_if.crc_rs1 = '0; crc_if.crc_flush = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_busy", 32'(crc_if.crc_busy), 32'd0);
      chk("rst_finish", 32'(crc_if.crc_finish), 32'd0);
      chk("rst_result", crc_if.crc_result, 32'd0);
      rst_l  = 1'b1;
      mon_en = 1'b1;
      @(posedge clk); #1;

      run_op(6'b000001, 32'h00000001, 32'h77073096, 0, 1'b0);
      run_op(6'b001000, 32'h00000001, 32'hF26B8303, 0, 1'b0);
      run_op(6'b000010, 32'h00000080, 32'h3B83984B, 0, 1'b0);
      run_op(6'b000100, 32'h00000000, 32'h00000000, 0, 1'b0);
      d = $urandom;
      run_op(6'b010000, d, ref_crc(6'b010000, d), 0, 1'b1);
      d = $urandom;
      run_op(6'b100000, d, ref_crc(6'b100000, d), 0, 1'b0);
      run_op(6'b000000, 32'h12345678, 32'h0, 0, 1'b0);
      idle_cycle(0);
      d = $urandom;
      run_op(6'b000100, d, ref_crc(6'b000100, d), 2, 1'b0);
      d = $urandom;
      run_op(6'b000001, d, ref_crc(6'b000001, d), 3, 1'b0);
      idle_cycle(2);
      d = $urandom;
      run_op(6'b101010, d, ref_crc(6'b101010, d), 0, 1'b0);

      mon_en = 1'b0;
      crc_if.crc_valid = 1'b1; crc_if.crc_type = 6'b000100; crc_if.crc_rs1 = $urandom;
      @(posedge clk); #1;
      crc_if.crc_valid = 1'b0;
      @(posedge clk); #2;
      rst_l = 1'b0;
      #1;
      chk("midrst_busy", 32'(crc_if.crc_busy), 32'd0);
      chk("midrst_finish", 32'(crc_if.crc_finish), 32'd0);
      chk("midrst_result", crc_if.crc_result, 32'd0);
      q.delete();
      last_res = '0; perf_model = '0; busy_lo = 1; busy_hi = 0;
      @(posedge clk); #1;
      rst_l  = 1'b1;
      mon_en = 1'b1;
      @(posedge clk); #1;

`ifdef EL2_CRC_PERF_CNT_EN
      for (int i = 0; i < 3; i++) begin
         d = $urandom;
         run_op(6'b000001, d, ref_crc(6'b000001, d), 0, 1'b0);
      end
      d = $urandom;
      run_op(6'b000010, d, ref_crc(6'b000010, d), 2, 1'b0);
      chk("perf_three", 32'(crc_if.crc_perf_cnt), 32'd3);
      force dut.r_perf_cnt = 16'hFFFE;
      perf_model = 16'hFFFE;
      #1;
      release dut.r_perf_cnt;
      for (int i = 0; i < 3; i++) begin
         d = $urandom;
         run_op(6'b001000, d, ref_crc(6'b001000, d), 0, 1'b0);
      end
      chk("perf_sat", 32'(crc_if.crc_perf_cnt), 32'h0000FFFF);
`endif

      for (int i = 0; i < 60; i++) begin
         t = ($urandom_range(0, 3) == 0) ? 6'($urandom) : 6'(1 << $urandom_range(0, 5));
         d = $urandom;
         fo = 0;
         if (t != 6'd0 && $urandom_range(0, 3) == 0) fo = $urandom_range(1, nbits_of(t) / BPC + 1);
         run_op(t, d, (t != 6'd0) ? ref_crc(t, d) : 32'd0, fo, ($urandom_range(0, 2) == 0));
         repeat ($urandom_range(0, 2)) idle_cycle($urandom_range(0, 2));
      end
      repeat (2) @(posedge clk);
      #1;
      chk("queue_drained", 32'(q.size()), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
